// File: rtl/pkg_display.sv
// Display-side constants: init and window command lists, frame size, FSM states.
// Shared by the frame scheduler, the command ROM and the image generator.
package pkg_display;

  localparam int DEF_FRAME_BYTES = 1024;

  // Display off, charge pump on, horizontal addressing, contrast, display on
  localparam int INIT_LEN = 8;
  localparam logic [0:INIT_LEN-1][7:0] INIT_CMDS = {
    8'hAE,
    8'h8D, 8'h14,
    8'h20, 8'h00,
    8'h81, 8'hCF,
    8'hAF
  };

  // Column window 0..127, page window 0..7
  localparam int WIN_LEN = 6;
  localparam logic [0:WIN_LEN-1][7:0] WINDOW_CMDS = {
    8'h21, 8'h00, 8'h7F,
    8'h22, 8'h00, 8'h07
  };

  localparam int CMD_W = 5;

  typedef enum logic [2:0] {
    RST_PANEL,
    WAKE,
    INIT,
    IDLE,
    WINDOW,
    DATA
  } fsm_t;

endpackage

// File: rtl/rom_comandos.sv
// Command ROM: index -> byte over INIT_CMDS followed by WINDOW_CMDS.
// Ports: idx (command index), cmd (command byte, 0 past the end).
module rom_comandos
  import pkg_display::*;
(
  input  logic [CMD_W-1:0] idx,
  output logic [7:0]       cmd
);

  always_comb begin
    cmd = 8'h00;
    for (int i = 0; i < INIT_LEN; i++) begin
      if (idx == CMD_W'(i)) cmd = INIT_CMDS[i];
    end
    for (int i = 0; i < WIN_LEN; i++) begin
      if (idx == CMD_W'(INIT_LEN + i)) cmd = WINDOW_CMDS[i];
    end
  end

endmodule

// File: rtl/controlador_quadro.sv
// Frame scheduler: panel reset, init commands, then window + pixel bytes
// per frame on state change or refresh timeout. Ports: clk, rst, estado,
// pix_data, tx_ready in; byte_counter, tx_valid, tx_data, tx_dc, io_reset,
// busy, frame_done out.
module controlador_quadro
  import pkg_display::*;
#(
  parameter int FRAME_BYTES    = pkg_display::DEF_FRAME_BYTES,
  parameter int RESET_CYCLES   = 1000,
  parameter int WAKE_CYCLES    = 1000,
  parameter int REFRESH_CYCLES = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] estado,
  input  logic [7:0] pix_data,
  output logic [9:0] byte_counter,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_dc,
  output logic       io_reset,
  output logic       busy,
  output logic       frame_done
);

  localparam int DLY_MAX =
    (RESET_CYCLES > WAKE_CYCLES) ? RESET_CYCLES : WAKE_CYCLES;
  localparam int DLY_W =
    (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
  localparam int REF_W =
    (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  fsm_t             state;
  logic [DLY_W-1:0] dly_cnt;
  logic [REF_W-1:0] ref_cnt;
  logic [CMD_W-1:0] cmd_idx;
  logic [CMD_W-1:0] rom_idx;
  logic [7:0]       rom_cmd;
  logic [7:0]       cmd_q;
  logic             pending;
  logic [3:0]       estado_q;
  logic             hs;

  assign hs = tx_valid & tx_ready;

  // ROM is addressed one entry ahead so the next byte is ready
  // at the handshake that consumes the current one.
  always_comb begin
    rom_idx = cmd_idx + 5'd1;
    if (state == WAKE) rom_idx = '0;
    else if (state == IDLE) rom_idx = CMD_W'(INIT_LEN);
  end

  rom_comandos u_rom (
    .idx (rom_idx),
    .cmd (rom_cmd)
  );

  // Pixel bytes pass straight through: pix_data is a pure function
  // of byte_counter, which only moves on a handshake.
  assign tx_data = (state == DATA) ? pix_data : cmd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RST_PANEL;
      io_reset     <= 1'b0;
      tx_valid     <= 1'b0;
      tx_dc        <= 1'b0;
      cmd_q        <= '0;
      byte_counter <= '0;
      busy         <= 1'b1;
      frame_done   <= 1'b0;
      dly_cnt      <= '0;
      ref_cnt      <= '0;
      cmd_idx      <= '0;
      pending      <= 1'b1;
      estado_q     <= estado;
    end else begin
      frame_done <= 1'b0;
      if (estado != estado_q) begin
        pending  <= 1'b1;
        estado_q <= estado;
      end
      unique case (state)
        RST_PANEL: begin
          if (dly_cnt == DLY_W'(RESET_CYCLES - 1)) begin
            dly_cnt  <= '0;
            io_reset <= 1'b1;
            state    <= WAKE;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        WAKE: begin
          if (dly_cnt == DLY_W'(WAKE_CYCLES - 1)) begin
            dly_cnt  <= '0;
            state    <= INIT;
            tx_valid <= 1'b1;
            tx_dc    <= 1'b0;
            cmd_idx  <= '0;
            cmd_q    <= rom_cmd;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        INIT: begin
          if (hs) begin
            if (cmd_idx == CMD_W'(INIT_LEN - 1)) begin
              state    <= IDLE;
              tx_valid <= 1'b0;
              busy     <= 1'b0;
            end else begin
              cmd_idx <= cmd_idx + 5'd1;
              cmd_q   <= rom_cmd;
            end
          end
        end
        IDLE: begin
          // Launch overrides a same-cycle change: that change is
          // absorbed into this frame, so only one frame goes out.
          if (pending ||
              ref_cnt == REF_W'(REFRESH_CYCLES - 1)) begin
            pending  <= 1'b0;
            ref_cnt  <= '0;
            estado_q <= estado;
            state    <= WINDOW;
            tx_valid <= 1'b1;
            tx_dc    <= 1'b0;
            busy     <= 1'b1;
            cmd_idx  <= CMD_W'(INIT_LEN);
            cmd_q    <= rom_cmd;
          end else begin
            ref_cnt <= ref_cnt + 1'b1;
          end
        end
        WINDOW: begin
          if (hs) begin
            if (cmd_idx == CMD_W'(INIT_LEN + WIN_LEN - 1)) begin
              state        <= DATA;
              tx_dc        <= 1'b1;
              byte_counter <= '0;
            end else begin
              cmd_idx <= cmd_idx + 5'd1;
              cmd_q   <= rom_cmd;
            end
          end
        end
        DATA: begin
          if (hs) begin
            if (byte_counter == 10'(FRAME_BYTES - 1)) begin
              byte_counter <= '0;
              frame_done   <= 1'b1;
              state        <= IDLE;
              tx_valid     <= 1'b0;
              tx_dc        <= 1'b0;
              busy         <= 1'b0;
            end else begin
              byte_counter <= byte_counter + 10'd1;
            end
          end
        end
        default: state <= RST_PANEL;
      endcase
    end
  end

endmodule

// File: doc/controlador_quadro.md
Name: controlador_quadro

Overview:
- Frame scheduler between the image generator and the byte-level SPI serializer of the 128x64 monochrome display.
- After reset it pulses the panel reset and streams the init command list.
- It then sends one full frame (window-setup commands, then 1024 pixel bytes) whenever `estado` changes or the refresh timer expires.
- It owns `byte_counter`, so the image generator only performs a lookup; the serializer only shifts bytes.

Parameters:
- FRAME_BYTES, 1024, pixel bytes per frame (128 columns x 8 pages).
- RESET_CYCLES, 1000, clk cycles `io_reset` is held low after `rst`.
- WAKE_CYCLES, 1000, clk cycles after `io_reset` release before the first command.
- REFRESH_CYCLES, 2_500_000, idle cycles before an unconditional frame redraw.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- estado  in  4  current pet state; any change requests a redraw.
- pix_data  in  8  pixel byte for the current `byte_counter`; combinational lookup, valid the same cycle.
- byte_counter  out  10  index of the pixel byte being sent (0..FRAME_BYTES-1).
- tx_valid  out  1  `tx_data`/`tx_dc` hold a byte for the serializer.
- tx_ready  in  1  serializer accepts the byte; a transfer happens when `tx_valid` and `tx_ready` are both 1 on a clk edge.
- tx_data  out  8  byte to shift out.
- tx_dc  out  1  0 = command byte, 1 = pixel data byte.
- io_reset  out  1  panel reset, active-low.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel byte of a frame is accepted.

Behaviour:
- Reset values (on `rst`, asynchronously):
  - State = RST_PANEL; `io_reset`=0.
  - `tx_valid`=0, `tx_data`=0, `tx_dc`=0, `byte_counter`=0.
  - `busy`=1, `frame_done`=0.
  - All counters = 0; `pending`=1 (first frame is forced); `estado_q`=`estado`.
- States and transitions:
  - RST_PANEL: `io_reset`=0 for RESET_CYCLES cycles -> WAKE.
  - WAKE: `io_reset`=1 for WAKE_CYCLES cycles -> INIT.
  - INIT: send INIT_CMDS[0..INIT_LEN-1] with `tx_dc`=0; after the last handshake -> IDLE.
  - IDLE: `busy`=0, `tx_valid`=0.
    - If `pending`, or the refresh counter reaches REFRESH_CYCLES-1: clear `pending`, clear the refresh counter, latch `estado_q`=`estado`, go to WINDOW.
    - The refresh counter counts only in IDLE.
  - WINDOW: send the 6 WINDOW_CMDS (0x21,0x00,0x7F,0x22,0x00,0x07) with `tx_dc`=0 -> DATA with `byte_counter`=0.
  - DATA: `tx_valid`=1, `tx_dc`=1, `tx_data`=`pix_data`.
    - On each handshake, `byte_counter` increments.
    - On the handshake at `byte_counter`=FRAME_BYTES-1: `byte_counter` returns to 0, `frame_done` pulses the next cycle, state -> IDLE.
- Handshake rules:
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data`, `tx_dc` and `byte_counter` hold stable. The image generator must keep `pix_data` a pure function of `byte_counter` and its inputs.
  - `tx_valid` never drops without a handshake, except on `rst`.
  - Back-to-back handshakes are allowed: one byte per cycle if `tx_ready` stays high.
- Change detection:
  - Every cycle, if `estado` != `estado_q`, set `pending`=1 and update `estado_q`.
  - A change during WINDOW or DATA does not abort the frame; the redraw starts from IDLE on the cycle after `frame_done`.
  - Multiple changes within one frame collapse into a single pending redraw.
  - If a change and a refresh timeout occur together, one frame is sent.
- Reset mid-operation: `rst` during any state aborts immediately (`tx_valid`=0 asynchronously) and restarts from RST_PANEL. The serializer must discard any partial byte.
- Widths:
  - Delay counter: clog2(max(RESET_CYCLES, WAKE_CYCLES)) bits.
  - Refresh counter: clog2(REFRESH_CYCLES) bits.
  - Command index: 5 bits.
  - `byte_counter` wraps only by explicit clear, never by overflow.

Decomposition:
- Shared package `pkg_display` holds:
  - INIT_LEN and the INIT_CMDS array (charge pump on, addressing mode horizontal, contrast, display on; max 25 entries).
  - WINDOW_CMDS.
  - The state encoding enum.
  - FRAME_BYTES default.
  - These are reused by `controlador_display` and `controlador_imagens`.
- One natural sub-module: `rom_comandos`, a combinational lookup (index -> command byte) over INIT_CMDS followed by WINDOW_CMDS.

Test Plan:
- Reset release with RESET_CYCLES=4, WAKE_CYCLES=4, `tx_ready`=1 -> `io_reset` low exactly 4 cycles, then high; first handshake after 4 more cycles is INIT_CMDS[0] with `tx_dc`=0; INIT_LEN command bytes follow.
- After init, `pix_data`=`byte_counter`[7:0] -> 6 window bytes 0x21,0x00,0x7F,0x22,0x00,0x07, then 1024 data bytes 0x00..0xFF repeated 4 times; `frame_done` pulses once; `busy` falls.
- `tx_ready` toggled randomly (50%) during DATA -> `tx_data`/`byte_counter` stable while stalled; no byte lost or duplicated (scoreboard of 1024 bytes).
- `estado` 0->3->5 during DATA at byte 200 -> current frame completes; exactly one extra frame starts the cycle after `frame_done`.
- Idle with REFRESH_CYCLES=50, `estado` constant -> a new frame starts every 50 idle cycles; `estado` change at cycle 50 together with timeout -> a single frame.
- `rst` asserted at `byte_counter`=512 with `tx_ready`=0 -> `tx_valid`=0 and `io_reset`=0 immediately; full init sequence repeats; the next frame starts at `byte_counter`=0.
